// File: rtl/tilemap_pkg.sv
// Shared tilemap constants, writer state encoding and the byte-lane to
// write-select mapping used by every tilemap write-port producer.
package tilemap_pkg;

    localparam int MAP_COLS_DEF = 40;
    localparam int MAP_ROWS_DEF = 30;
    localparam int TM_ADDR_W    = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_t;

    // Byte offset 0 is the most significant lane (wdata[31:24], wselect[3]).
    function automatic logic [3:0] lane_bit(input logic [1:0] offset);
        return 4'b1000 >> offset;
    endfunction

endpackage

// File: rtl/tilemap_lane_mask.sv
// Given the lane offset inside a word and the cells left in the row, returns
// how many cells one word write covers and the matching byte enables.
module tilemap_lane_mask
    import tilemap_pkg::*;
(
    input  logic [1:0] lane,
    input  logic [7:0] remaining,
    output logic [2:0] count,
    output logic [3:0] wselect
);

    logic [2:0] room;

    assign room = 3'd4 - {1'b0, lane};

    always_comb begin
        count   = (remaining < {5'd0, room}) ? remaining[2:0] : room;
        wselect = '0;
        for (int j = 0; j < 4; j++) begin
            if (j >= int'(lane) && j < int'(lane) + int'(count))
                wselect = wselect | lane_bit(2'(j));
        end
    end

endmodule

// File: rtl/tilemap_rect_writer.sv
// Fills a clipped rectangle of tilemap cells with one tile index, emitting
// merged byte-enabled word writes, one per cycle while the store accepts them.
module tilemap_rect_writer
    import tilemap_pkg::*;
#(
    parameter int          MAP_COLS  = MAP_COLS_DEF,
    parameter int          MAP_ROWS  = MAP_ROWS_DEF,
    parameter int          ADDR_W    = 27,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [5:0]        i_cmd_x,
    input  logic [5:0]        i_cmd_y,
    input  logic [6:0]        i_cmd_w,
    input  logic [6:0]        i_cmd_h,
    input  logic [7:0]        i_cmd_tile,
    output logic [31:0]       o_wdata,
    output logic              o_wea,
    output logic [3:0]        o_wselect,
    output logic [ADDR_W-1:0] o_waddr,
    input  logic              i_wready,
    output logic              o_busy,
    output logic              o_done
);

    wr_state_t state, state_n;

    logic [5:0] col_q, col_n, row_q, row_n, x_q, x_n;
    logic [7:0] x_end_q, x_end_n, y_end_q, y_end_n, tile_q, tile_n;
    logic [2:0] n_q, n_n;

    logic [7:0]           x_sum, y_sum, col_adv, row_inc, remaining;
    logic                 empty_cmd;
    logic [TM_ADDR_W-1:0] lin_addr;
    logic [ADDR_W-1:0]    byte_addr;
    logic [3:0]           wsel_n;
    logic                 wea_n;

    assign x_sum     = {2'b00, i_cmd_x} + {1'b0, i_cmd_w};
    assign y_sum     = {2'b00, i_cmd_y} + {1'b0, i_cmd_h};
    assign empty_cmd = (i_cmd_w == '0) || (i_cmd_h == '0) ||
                       ({2'b00, i_cmd_x} >= 8'(MAP_COLS)) ||
                       ({2'b00, i_cmd_y} >= 8'(MAP_ROWS));
    assign col_adv   = {2'b00, col_q} + {5'd0, n_q};
    assign row_inc   = {2'b00, row_q} + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        col_n   = col_q;
        row_n   = row_q;
        x_n     = x_q;
        x_end_n = x_end_q;
        y_end_n = y_end_q;
        tile_n  = tile_q;
        unique case (state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    col_n   = i_cmd_x;
                    row_n   = i_cmd_y;
                    x_n     = i_cmd_x;
                    tile_n  = i_cmd_tile;
                    x_end_n = (x_sum > 8'(MAP_COLS)) ? 8'(MAP_COLS) : x_sum;
                    y_end_n = (y_sum > 8'(MAP_ROWS)) ? 8'(MAP_ROWS) : y_sum;
                    state_n = empty_cmd ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (i_wready) begin
                    if (col_adv >= x_end_q) begin
                        col_n = x_q;
                        row_n = row_inc[5:0];
                        if (row_inc >= y_end_q) state_n = ST_DONE;
                    end else begin
                        col_n = col_adv[5:0];
                    end
                end
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Next write is derived from the next cursor so the port is fully registered.
    assign lin_addr  = TM_ADDR_W'(row_n) * TM_ADDR_W'(MAP_COLS) + TM_ADDR_W'(col_n);
    assign byte_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(lin_addr);
    assign remaining = x_end_n - {2'b00, col_n};
    assign wea_n     = (state_n == ST_WRITE);

    tilemap_lane_mask u_lane_mask (
        .lane      (byte_addr[1:0]),
        .remaining (remaining),
        .count     (n_n),
        .wselect   (wsel_n)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q       <= '0;
            row_q       <= '0;
            x_q         <= '0;
            x_end_q     <= '0;
            y_end_q     <= '0;
            tile_q      <= '0;
            n_q         <= '0;
            o_wea       <= 1'b0;
            o_wselect   <= '0;
            o_waddr     <= '0;
            o_wdata     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_cmd_ready <= 1'b0;
        end else begin
            col_q       <= col_n;
            row_q       <= row_n;
            x_q         <= x_n;
            x_end_q     <= x_end_n;
            y_end_q     <= y_end_n;
            tile_q      <= tile_n;
            n_q         <= n_n;
            o_wea       <= wea_n;
            o_wselect   <= wea_n ? wsel_n : 4'b0000;
            o_waddr     <= wea_n ? {byte_addr[ADDR_W-1:2], 2'b00} : '0;
            o_wdata     <= wea_n ? {4{tile_n}} : 32'd0;
            o_busy      <= wea_n;
            o_done      <= (state_n == ST_DONE);
            o_cmd_ready <= (state_n == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_tilemap_rect_writer.sv
// Directed bench for tilemap_rect_writer: rectangle fills, clipping, empty
// commands, write backpressure and reset in the middle of a command.
module tb_tilemap_rect_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [5:0]  i_cmd_x, i_cmd_y;
    logic [6:0]  i_cmd_w, i_cmd_h;
    logic [7:0]  i_cmd_tile;
    logic [31:0] o_wdata;
    logic        o_wea;
    logic [3:0]  o_wselect;
    logic [26:0] o_waddr;
    logic        i_wready;
    logic        o_busy;
    logic        o_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [26:0] wa_q[$];
    logic [3:0]  ws_q[$];
    logic [31:0] wd_q[$];
    int          done_cnt, done_cyc, last_wr_cyc;

    tilemap_rect_writer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_x     (i_cmd_x),
        .i_cmd_y     (i_cmd_y),
        .i_cmd_w     (i_cmd_w),
        .i_cmd_h     (i_cmd_h),
        .i_cmd_tile  (i_cmd_tile),
        .o_wdata     (o_wdata),
        .o_wea       (o_wea),
        .o_wselect   (o_wselect),
        .o_waddr     (o_waddr),
        .i_wready    (i_wready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // stall_mode 1 toggles i_wready; abort_after > 0 returns once that many writes were issued.
    task automatic run_cmd(input logic [5:0] x, input logic [5:0] y, input logic [6:0] w,
                           input logic [6:0] h, input logic [7:0] tile,
                           input int stall_mode, input int abort_after);
        int          cyc;
        bit          finished, prev_stall;
        logic [26:0] p_addr;
        logic [3:0]  p_sel;
        logic [31:0] p_data;
        wa_q.delete(); ws_q.delete(); wd_q.delete();
        done_cnt = 0; done_cyc = -1; last_wr_cyc = -1;
        finished = 0; prev_stall = 0; cyc = 0;
        p_addr = '0; p_sel = '0; p_data = '0;
        @(negedge clk);
        chk("ready_idle", o_cmd_ready, 1);
        i_cmd_valid = 1; i_cmd_x = x; i_cmd_y = y; i_cmd_w = w; i_cmd_h = h; i_cmd_tile = tile;
        i_wready = 1'b0;
        @(posedge clk);
        #1 i_cmd_valid = 0;
        while (!finished && cyc < 300) begin
            @(negedge clk);
            cyc++;
            i_wready = (stall_mode == 1) ? (cyc % 2 == 0) : 1'b1;
            if (prev_stall) begin
                chk("stall_wea", o_wea, 1);
                chk("stall_addr", o_waddr, p_addr);
                chk("stall_sel", o_wselect, p_sel);
                chk("stall_data", o_wdata, p_data);
            end
            prev_stall = o_wea && !i_wready;
            p_addr = o_waddr; p_sel = o_wselect; p_data = o_wdata;
            if (o_wea) chk("busy_in_write", o_busy, 1);
            if (o_wea && i_wready) begin
                wa_q.push_back(o_waddr); ws_q.push_back(o_wselect); wd_q.push_back(o_wdata);
                last_wr_cyc = cyc;
                if (abort_after > 0 && wa_q.size() == abort_after) return;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("wea_in_done", o_wea, 0);
                chk("busy_in_done", o_busy, 0);
            end
            if (done_cnt > 0 && cyc >= done_cyc + 2) finished = 1;
        end
        chk("cmd_finished", finished, 1);
        chk("done_once", done_cnt, 1);
        chk("ready_back", o_cmd_ready, 1);
    endtask

    task automatic check_small(input string tag);
        chk({tag, "_nwr"}, wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            chk({tag, "_a0"}, wa_q[0], 40);
            chk({tag, "_s0"}, ws_q[0], 4'b0011);
            chk({tag, "_d0"}, wd_q[0], 32'h3C3C3C3C);
            chk({tag, "_a1"}, wa_q[1], 44);
            chk({tag, "_s1"}, ws_q[1], 4'b1110);
            chk({tag, "_d1"}, wd_q[1], 32'h3C3C3C3C);
        end
        chk({tag, "_done_lat"}, done_cyc, last_wr_cyc + 1);
    endtask

    initial begin
        reset_n = 0; i_cmd_valid = 0; i_wready = 0;
        i_cmd_x = 0; i_cmd_y = 0; i_cmd_w = 0; i_cmd_h = 0; i_cmd_tile = 0;
        #12;
        chk("rst_wea", o_wea, 0);
        chk("rst_ready", o_cmd_ready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_addr", o_waddr, 0);
        chk("rst_sel", o_wselect, 0);
        chk("rst_data", o_wdata, 0);
        @(negedge clk); reset_n = 1;

        run_cmd(6'd2, 6'd1, 7'd5, 7'd1, 8'h3C, 0, 0);
        check_small("t1");

        run_cmd(6'd0, 6'd0, 7'd40, 7'd2, 8'h07, 0, 0);
        chk("full_nwr", wa_q.size(), 20);
        for (int i = 0; i < wa_q.size(); i++) begin
            chk($sformatf("full_a%0d", i), wa_q[i], 27'(4 * i));
            chk($sformatf("full_s%0d", i), ws_q[i], 4'b1111);
            chk($sformatf("full_d%0d", i), wd_q[i], 32'h07070707);
        end

        run_cmd(6'd38, 6'd29, 7'd10, 7'd5, 8'hA5, 0, 0);
        chk("clip_nwr", wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            chk("clip_a0", wa_q[0], 1196);
            chk("clip_s0", ws_q[0], 4'b0011);
            chk("clip_d0", wd_q[0], 32'hA5A5A5A5);
        end

        run_cmd(6'd3, 6'd3, 7'd0, 7'd4, 8'h11, 0, 0);
        chk("w0_nwr", wa_q.size(), 0);
        chk("w0_done_lat", (done_cyc >= 1 && done_cyc <= 2), 1);

        run_cmd(6'd40, 6'd3, 7'd4, 7'd4, 8'h11, 0, 0);
        chk("x40_nwr", wa_q.size(), 0);
        chk("x40_done_lat", (done_cyc >= 1 && done_cyc <= 2), 1);

        run_cmd(6'd2, 6'd1, 7'd5, 7'd1, 8'h3C, 1, 0);
        check_small("stall");

        // Abort during row 1: write 11 starts row 1, reset lands after write 12.
        run_cmd(6'd0, 6'd0, 7'd40, 7'd2, 8'h07, 0, 12);
        chk("abort_nwr", wa_q.size(), 12);
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("abort_wea", o_wea, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_ready", o_cmd_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", o_done, 0);
        end
        reset_n = 1;
        @(negedge clk);
        chk("abort_ready_after", o_cmd_ready, 1);
        chk("abort_no_done_after", o_done, 0);

        run_cmd(6'd2, 6'd1, 7'd5, 7'd1, 8'h3C, 0, 0);
        check_small("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
